de2_70_nios2_processor_mul_seq: RTL and testbench

DE2_70_NIOS2_PROCESSOR_MUL_SEQ -- requirements
Module: de2_70_nios2_processor_mul_seq

---
 rtl/de2_70_nios2_processor_mul_pkg.sv | 18 +
 rtl/de2_70_nios2_processor_mul_seq.sv | 130 +++++++++++++
 tb/tb_de2_70_nios2_processor_mul_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/de2_70_nios2_processor_mul_pkg.sv
// Shared definitions for the sequential multiplier front end.
// Holds the sequencer state type, the pass-count constants and the
// latency of the external 16-bit multiply cell.
package de2_70_nios2_processor_mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_ACC,
    ST_DONE
  } mul_state_e;

  localparam int unsigned MUL_PASSES_FULL  = 2;
  localparam int unsigned MUL_PASSES_SKIP  = 1;
  localparam int unsigned MUL_CELL_LATENCY = 1;

endpackage

// File: rtl/de2_70_nios2_processor_mul_seq.sv
// Sequencer that produces the low 32 bits of a 32x32 multiply using an
// external 16-bit multiply cell (one cycle latency) in one or two passes.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_src1 = A, req_src2 = B
//   rsp_valid/rsp_ready   response handshake; rsp_result = (A*B) mod 2^32
//   A_mul_src1/A_mul_src2 operands to the mult cell (only src2[15:0] used)
//   A_mul_cell_result     cell product, valid one cycle after operands
//
// HI_SKIP = 1 skips the second pass when B[31:16] is zero.
module de2_70_nios2_processor_mul_seq
  import de2_70_nios2_processor_mul_pkg::*;
#(
  parameter int unsigned HI_SKIP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result
);

  localparam bit SKIP_EN = (HI_SKIP != 0);

  mul_state_e  state;
  mul_state_e  next_state;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] acc_q;
  logic [31:0] result_q;

  logic        latch_ops;
  logic        load_acc;
  logic        load_result;
  logic [31:0] result_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The cell result seen in P2 is the low-half product issued in P1; the
  // one seen in ACC is the high-half product issued in P2.
  always_comb begin
    next_state  = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    A_mul_src1  = '0;
    A_mul_src2  = '0;
    latch_ops   = 1'b0;
    load_acc    = 1'b0;
    load_result = 1'b0;
    result_d    = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch_ops  = 1'b1;
          next_state = ST_P1;
        end
      end
      ST_P1: begin
        A_mul_src1 = a_q;
        A_mul_src2 = {16'h0000, b_q[15:0]};
        next_state = ST_P2;
      end
      ST_P2: begin
        A_mul_src1 = a_q;
        A_mul_src2 = {16'h0000, b_q[31:16]};
        load_acc   = 1'b1;
        if (SKIP_EN && (b_q[31:16] == 16'h0000)) begin
          load_result = 1'b1;
          result_d    = A_mul_cell_result;
          next_state  = ST_DONE;
        end else begin
          next_state = ST_ACC;
        end
      end
      ST_ACC: begin
        load_result = 1'b1;
        result_d    = acc_q + (A_mul_cell_result << 16);
        next_state  = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (latch_ops) begin
        a_q <= req_src1;
        b_q <= req_src2;
      end
      if (load_acc) begin
        acc_q <= A_mul_cell_result;
      end
      if (load_result) begin
        result_q <= result_d;
      end
    end
  end

  assign rsp_result = result_q;

endmodule

// File: tb/tb_de2_70_nios2_processor_mul_seq.sv
// Directed and random checks of the multiply sequencer, HI_SKIP = 1 and 0.
// Each DUT gets its own behavioural 16-bit mult cell with one-cycle latency.
module tb_de2_70_nios2_processor_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        rsp_ready;
  logic [31:0] req_src1;
  logic [31:0] req_src2;

  logic        req_valid0, req_ready0, rsp_valid0;
  logic [31:0] rsp_result0, mul_src1_0, mul_src2_0, cell_0;
  logic        req_valid1, req_ready1, rsp_valid1;
  logic [31:0] rsp_result1, mul_src1_1, mul_src2_1, cell_1;

  logic        sel;
  logic        mx_ready, mx_valid;
  logic [31:0] mx_result, mx_src1, mx_src2;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  de2_70_nios2_processor_mul_seq #(.HI_SKIP(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_result(rsp_result0),
    .A_mul_src1(mul_src1_0), .A_mul_src2(mul_src2_0),
    .A_mul_cell_result(cell_0)
  );

  de2_70_nios2_processor_mul_seq #(.HI_SKIP(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
    .A_mul_src1(mul_src1_1), .A_mul_src2(mul_src2_1),
    .A_mul_cell_result(cell_1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_0 <= '0;
      cell_1 <= '0;
    end else begin
      cell_0 <= mul_src1_0 * {16'h0000, mul_src2_0[15:0]};
      cell_1 <= mul_src1_1 * {16'h0000, mul_src2_1[15:0]};
    end
  end

  always_comb begin
    if (sel) begin
      mx_ready = req_ready1; mx_valid = rsp_valid1; mx_result = rsp_result1;
      mx_src1 = mul_src1_1;  mx_src2 = mul_src2_1;
    end else begin
      mx_ready = req_ready0; mx_valid = rsp_valid0; mx_result = rsp_result0;
      mx_src1 = mul_src1_0;  mx_src2 = mul_src2_0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble the request bus after accept, optionally
  // hold rsp_ready low for `hold` cycles in DONE, then retire the response.
  task automatic do_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int unsigned lat,
                        input int unsigned hold, input string tag);
    int unsigned n;
    sel = s;
    req_src1 = a;
    req_src2 = b;
    if (s) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    #1;
    check({tag, " idle_ready"}, {31'd0, mx_ready}, 32'd1);
    check({tag, " idle_src1"}, mx_src1, 32'd0);
    step();
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_src1 = $urandom;
    req_src2 = $urandom;
    check({tag, " p1_src1"}, mx_src1, a);
    check({tag, " p1_src2"}, mx_src2, {16'h0000, b[15:0]});
    n = 0;
    while (mx_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, mx_result, exp);
    check({tag, " done_ops"}, mx_src1 | mx_src2, 32'd0);
    check({tag, " done_ready"}, {31'd0, mx_ready}, 32'd0);
    for (int i = 0; i < int'(hold); i++) begin
      step();
      check({tag, " stall_valid"}, {31'd0, mx_valid}, 32'd1);
      check({tag, " stall_result"}, mx_result, exp);
      check({tag, " stall_ready"}, {31'd0, mx_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " back_idle"}, {31'd0, mx_ready}, 32'd1);
    check({tag, " valid_drop"}, {31'd0, mx_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int unsigned lat;

    reset_n = 1'b0;
    rsp_ready = 1'b0;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_src1 = '0;
    req_src2 = '0;
    sel = 1'b1;
    #2;
    check("rst ready1", {31'd0, req_ready1}, 32'd1);
    check("rst valid1", {31'd0, rsp_valid1}, 32'd0);
    check("rst result1", rsp_result1, 32'd0);
    check("rst ops1", mul_src1_1 | mul_src2_1, 32'd0);
    check("rst ready0", {31'd0, req_ready0}, 32'd1);
    check("rst result0", rsp_result0, 32'd0);
    #10;
    reset_n = 1'b1;
    step();

    do_req(1'b1, 32'd3, 32'd5, 32'h0000000F, 2, 0, "skip_3x5");
    do_req(1'b1, 32'h00000003, 32'h00020001, 32'h00060003, 3, 0, "two_pass");
    do_req(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3, 0, "all_ones");
    do_req(1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 3, 0, "wrap");
    do_req(1'b1, 32'h12345678, 32'h00009ABC, 32'h4CC8A6A0 * 32'd0 + 32'h12345678 * 32'h00009ABC, 2, 5, "stall");
    do_req(1'b0, 32'd3, 32'd5, 32'h0000000F, 3, 0, "noskip_3x5");
    do_req(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3, 0, "noskip_ones");

    // Abort in ACC: the two-pass request is cut off by reset.
    sel = 1'b1;
    req_src1 = 32'h00000003;
    req_src2 = 32'h00020001;
    req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    step();
    step();
    check("acc_no_valid", {31'd0, rsp_valid1}, 32'd0);
    check("acc_not_ready", {31'd0, req_ready1}, 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort ready", {31'd0, req_ready1}, 32'd1);
    check("abort valid", {31'd0, rsp_valid1}, 32'd0);
    check("abort result", rsp_result1, 32'd0);
    check("abort ops", mul_src1_1 | mul_src2_1, 32'd0);
    #1;
    reset_n = 1'b1;
    step();
    do_req(1'b1, 32'd7, 32'd6, 32'h0000002A, 2, 0, "after_abort");

    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      if ((i % 4) == 0) b = b & 32'h0000FFFF;
      s = i[0];
      lat = (s && b[31:16] == 16'h0000) ? 2 : 3;
      do_req(s, a, b, a * b, lat, 0, "random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
